// File: rtl/line_clear_engine.sv
// line_clear_engine
//   Post-lock line clear pass over the playfield matrix memory. Walks the rows
//   bottom (size_p-1) to top (0) through the line read port, drops every
//   completely filled row, copies the surviving rows downward, then zero-fills
//   as many top rows as were removed. The number of removed rows is reported
//   on lines_cleared_o.
//
// Ports
//   clk_i, reset_i     clock, asynchronous active-low reset
//   start_i            request a pass (accepted in IDLE while mem_ready_i=1)
//   ready_o            engine is idle
//   done_o             one-cycle pulse at the end of a pass
//   lines_cleared_o    rows cleared by the last completed pass
//   mem_ready_i        memory in normal mode; low stalls all port activity
//   rd_addr_o/rd_v_o   line read request (data returns one cycle later)
//   rd_data_i          registered read data
//   wr_addr_o/wr_data_o/wr_v_o  line write port
module line_clear_engine #(
    parameter int word_width_p = 10,
    parameter int size_p       = 20
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          start_i,
    output logic                          ready_o,
    output logic                          done_o,
    output logic [$clog2(size_p):0]       lines_cleared_o,
    input  logic                          mem_ready_i,
    output logic [$clog2(size_p)-1:0]     rd_addr_o,
    output logic                          rd_v_o,
    input  logic [word_width_p-1:0]       rd_data_i,
    output logic [$clog2(size_p)-1:0]     wr_addr_o,
    output logic [word_width_p-1:0]       wr_data_o,
    output logic                          wr_v_o
);
    localparam int AW = $clog2(size_p);
    localparam int CW = $clog2(size_p) + 1;
    localparam logic [AW-1:0] LAST_ROW = AW'(size_p - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EVAL,
        S_FILL,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] src_q, src_d;     // row being read
    logic [AW-1:0] dst_q, dst_d;     // next row to receive a surviving row
    logic [CW-1:0] count_q, count_d; // full rows seen this pass
    logic [CW-1:0] lines_q, lines_d;
    logic          row_full;

    assign row_full = &rd_data_i;

    // State register
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
            src_q   <= LAST_ROW;
            dst_q   <= LAST_ROW;
            count_q <= '0;
            lines_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            count_q <= count_d;
            lines_q <= lines_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        count_d = count_q;
        lines_d = lines_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && mem_ready_i) begin
                    src_d   = LAST_ROW;
                    dst_d   = LAST_ROW;
                    count_d = '0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (mem_ready_i) state_d = S_EVAL;
            end
            S_EVAL: begin
                // A stall holds everything; the memory keeps the registered
                // address so rd_data_i is still the same row afterwards.
                if (mem_ready_i) begin
                    if (row_full) begin
                        count_d = count_q + CW'(1);
                    end else if (dst_q != '0) begin
                        dst_d = dst_q - AW'(1);
                    end
                    if (src_q == '0) begin
                        if (count_d != '0) begin
                            state_d = S_FILL;
                        end else begin
                            state_d = S_DONE;
                            lines_d = count_d;
                        end
                    end else begin
                        src_d   = src_q - AW'(1);
                        state_d = S_READ;
                    end
                end
            end
            S_FILL: begin
                // dst ends compaction at count-1, so this zeroes rows
                // count-1 down to 0.
                if (mem_ready_i) begin
                    if (dst_q == '0) begin
                        state_d = S_DONE;
                        lines_d = count_q;
                    end else begin
                        dst_d = dst_q - AW'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: addresses and data are forced to 0 unless their strobe is high
    always_comb begin
        ready_o         = (state_q == S_IDLE);
        done_o          = (state_q == S_DONE);
        lines_cleared_o = lines_q;
        rd_v_o          = (state_q == S_READ) && mem_ready_i;
        rd_addr_o       = rd_v_o ? src_q : '0;
        wr_v_o          = 1'b0;
        wr_addr_o       = '0;
        wr_data_o       = '0;
        case (state_q)
            S_EVAL: begin
                // A surviving row that is already in place needs no write.
                if (mem_ready_i && !row_full && (src_q != dst_q)) begin
                    wr_v_o    = 1'b1;
                    wr_addr_o = dst_q;
                    wr_data_o = rd_data_i;
                end
            end
            S_FILL: begin
                if (mem_ready_i) begin
                    wr_v_o    = 1'b1;
                    wr_addr_o = dst_q;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_line_clear_engine.sv
module tb_line_clear_engine;
    localparam int W    = 10;
    localparam int SIZE = 20;
    localparam int AW   = $clog2(SIZE);

    typedef logic [SIZE-1:0][W-1:0] field_t;

    typedef struct {
        field_t init;
        int     srow;
        int     slen;
        int     ecnt;
        int     elat;
        int     ewr;
        field_t efin;
    } vec_t;

    typedef struct {
        int           addr;
        logic [W-1:0] data;
    } wr_t;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          start_i = 1'b0;
    logic          mem_ready_i = 1'b1;
    logic          ready_o, done_o, rd_v_o, wr_v_o;
    logic [AW:0]   lines_cleared_o;
    logic [AW-1:0] rd_addr_o, wr_addr_o;
    logic [W-1:0]  wr_data_o;
    logic [W-1:0]  rd_q = '0;

    int total = 0;
    int bad   = 0;

    // memory model and bus monitor
    logic [W-1:0] mem [SIZE];
    field_t       load_field = '0;
    logic         load_en = 1'b0;
    logic         mon_en = 1'b0;
    int           n_rd = 0;
    int           n_viol = 0;
    wr_t          wrq[$];

    always #5 clk_i = ~clk_i;

    line_clear_engine #(.word_width_p(W), .size_p(SIZE)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
        .ready_o(ready_o), .done_o(done_o), .lines_cleared_o(lines_cleared_o),
        .mem_ready_i(mem_ready_i), .rd_addr_o(rd_addr_o), .rd_v_o(rd_v_o),
        .rd_data_i(rd_q), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .wr_v_o(wr_v_o)
    );

    always @(posedge clk_i) begin
        if (load_en) begin
            for (int r = 0; r < SIZE; r++) mem[r] <= load_field[r];
        end else if (wr_v_o) begin
            mem[wr_addr_o] <= wr_data_o;
        end
        if (rd_v_o) rd_q <= mem[rd_addr_o];
    end

    always @(posedge clk_i) begin
        if (mon_en) begin
            if (rd_v_o) n_rd <= n_rd + 1;
            if (wr_v_o) wrq.push_back('{addr: int'(wr_addr_o), data: wr_data_o});
            if ((rd_v_o && wr_v_o) || (!mem_ready_i && (rd_v_o || wr_v_o)))
                n_viol <= n_viol + 1;
        end else begin
            n_rd   <= 0;
            n_viol <= 0;
            wrq.delete();
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chkf(input string nm, input field_t act, input field_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: a full row vanishes; every other row keeps its order and
    // lands as far down as it can. A surviving row is written only if at
    // least one full row sat below it; each removed row costs one zero write.
    function automatic void ref_model(input field_t init, output field_t fin,
                                      output int cnt, output int nwr);
        logic [W-1:0] keep[$];
        cnt = 0;
        nwr = 0;
        for (int r = SIZE - 1; r >= 0; r--) begin
            if (&init[r]) cnt++;
            else begin
                keep.push_back(init[r]);
                if (cnt > 0) nwr++;
            end
        end
        fin = '0;
        for (int i = 0; i < keep.size(); i++) fin[SIZE-1-i] = keep[i];
        nwr += cnt;
    endfunction

    task automatic load(input field_t f);
        @(negedge clk_i);
        mon_en     = 1'b0;
        load_field = f;
        load_en    = 1'b1;
        @(negedge clk_i);
        load_en    = 1'b0;
    endtask

    task automatic run_pass(input string nm, input field_t init, input int srow,
                            input int slen, input int ecnt, input int elat,
                            input int ewr, input field_t efin);
        int     cyc = 0;
        bit     got = 0;
        int     stall_left = 0;
        bit     stalled = 0;
        bit     prev_rd = 0;
        int     prev_addr = -1;
        bit     ok;
        field_t fin;
        load(init);
        mon_en      = 1'b1;
        mem_ready_i = 1'b1;
        start_i     = 1'b1;
        while (cyc < 300) begin
            @(negedge clk_i);
            cyc++;
            if (cyc == 1) start_i = 1'b0;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) mem_ready_i = 1'b1;
            end else if (!stalled && slen > 0 && prev_rd && prev_addr == srow) begin
                // engine is now evaluating row srow
                mem_ready_i = 1'b0;
                stall_left  = slen;
                stalled     = 1'b1;
            end
            #1;
            if (done_o) begin
                got = 1;
                break;
            end
            prev_rd   = rd_v_o;
            prev_addr = int'(rd_addr_o);
        end
        mem_ready_i = 1'b1;
        chk({nm, "_done_seen"}, got, 1);
        chk({nm, "_latency"}, cyc, elat);
        chk({nm, "_lines"}, lines_cleared_o, ecnt);
        for (int r = 0; r < SIZE; r++) fin[r] = mem[r];
        chkf({nm, "_field"}, fin, efin);
        chk({nm, "_reads"}, n_rd, SIZE);
        chk({nm, "_writes"}, wrq.size(), ewr);
        ok = 1;
        if (wrq.size() < ecnt) ok = 0;
        else begin
            for (int j = 0; j < ecnt; j++) begin
                wr_t w;
                w = wrq[wrq.size() - ecnt + j];
                if (w.addr != ecnt - 1 - j || w.data != '0) ok = 0;
            end
        end
        chk({nm, "_fill_writes"}, ok, 1);
        chk({nm, "_bus_violations"}, n_viol, 0);
        @(negedge clk_i);
        #1;
        chk({nm, "_done_pulse_ready"}, {done_o, ready_o}, 2'b01);
        mon_en = 1'b0;
    endtask

    initial begin
        vec_t   tv[7];
        field_t f, fin;
        int     cnt, nwr, srow, slen;

        // directed vectors
        for (int i = 0; i < 7; i++) begin
            tv[i].init = '0; tv[i].efin = '0; tv[i].srow = 0; tv[i].slen = 0;
        end
        // empty field
        tv[0].ecnt = 0; tv[0].elat = 41; tv[0].ewr = 0;
        // bottom row full, row 18 survives
        tv[1].init[19] = 10'h3FF; tv[1].init[18] = 10'h001;
        tv[1].efin[19] = 10'h001;
        tv[1].ecnt = 1; tv[1].elat = 42; tv[1].ewr = 20;
        // non-adjacent full rows
        tv[2].init[19] = 10'h3FF; tv[2].init[18] = 10'h0F0;
        tv[2].init[17] = 10'h3FF; tv[2].init[16] = 10'h00F;
        tv[2].efin[19] = 10'h0F0; tv[2].efin[18] = 10'h00F;
        tv[2].ecnt = 2; tv[2].elat = 43; tv[2].ewr = 20;
        // four bottom rows full
        for (int r = 16; r < 20; r++) tv[3].init[r] = 10'h3FF;
        tv[3].ecnt = 4; tv[3].elat = 45; tv[3].ewr = 20;
        // every row full: count reaches size
        for (int r = 0; r < 20; r++) tv[4].init[r] = 10'h3FF;
        tv[4].ecnt = 20; tv[4].elat = 61; tv[4].ewr = 20;
        // only the top row full
        tv[5].init[0] = 10'h3FF; tv[5].init[19] = 10'h2AA;
        tv[5].efin[19] = 10'h2AA;
        tv[5].ecnt = 1; tv[5].elat = 42; tv[5].ewr = 1;
        // same as the non-adjacent case with a 5-cycle stall in EVAL of row 10
        tv[6] = tv[2];
        tv[6].srow = 10; tv[6].slen = 5; tv[6].elat = 48;

        // reset state
        #3 reset_i = 1'b0;
        #1;
        chk("rst_ready", ready_o, 1);
        chk("rst_done", done_o, 0);
        chk("rst_lines", lines_cleared_o, 0);
        chk("rst_strobes", {rd_v_o, wr_v_o}, 0);
        chk("rst_addr_data", {rd_addr_o, wr_addr_o, wr_data_o}, 0);
        repeat (2) @(negedge clk_i);
        reset_i = 1'b1;

        // start without mem_ready is ignored
        @(negedge clk_i);
        mem_ready_i = 1'b0;
        start_i     = 1'b1;
        @(negedge clk_i);
        start_i     = 1'b0;
        mem_ready_i = 1'b1;
        #1;
        chk("start_ignored_ready", ready_o, 1);
        chk("start_ignored_rd_v", rd_v_o, 0);

        for (int i = 0; i < 7; i++)
            run_pass($sformatf("vec%0d", i), tv[i].init, tv[i].srow, tv[i].slen,
                     tv[i].ecnt, tv[i].elat, tv[i].ewr, tv[i].efin);

        // reset in the middle of FILL
        load(tv[3].init);
        start_i = 1'b1;
        for (int c = 1; c <= 42; c++) begin
            @(negedge clk_i);
            if (c == 1) start_i = 1'b0;
        end
        #1;
        chk("abort_in_fill_addr", wr_v_o ? int'(wr_addr_o) : 99, 2);
        reset_i = 1'b0;
        #1;
        chk("abort_ready", ready_o, 1);
        chk("abort_lines", lines_cleared_o, 0);
        chk("abort_strobes", {rd_v_o, wr_v_o, done_o}, 0);
        chk("abort_addr_data", {rd_addr_o, wr_addr_o, wr_data_o}, 0);
        @(negedge clk_i);
        reset_i = 1'b1;
        #1;
        chk("abort_ready_after", ready_o, 1);
        run_pass("after_abort", tv[2].init, 0, 0, tv[2].ecnt, tv[2].elat,
                 tv[2].ewr, tv[2].efin);

        // random fields against the reference model
        for (int p = 0; p < 25; p++) begin
            for (int r = 0; r < SIZE; r++) begin
                if ($urandom_range(0, 3) == 0) f[r] = '1;
                else f[r] = W'($urandom);
            end
            ref_model(f, fin, cnt, nwr);
            if ($urandom_range(0, 1) == 1) begin
                srow = $urandom_range(0, SIZE - 1);
                slen = $urandom_range(1, 4);
            end else begin
                srow = 0;
                slen = 0;
            end
            run_pass($sformatf("rnd%0d", p), f, srow, slen, cnt,
                     2 * SIZE + cnt + 1 + slen, nwr, fin);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/line_clear_engine.md
Name: line_clear_engine

Overview:
- Post-lock stage that runs after a falling piece has been written into the playfield matrix memory.
- Scans the playfield from the bottom row to the top row through the memory's line read port (port 2) and line write port (write port 1).
- Removes every completely filled row, compacts the remaining rows downward and zero-fills the vacated top rows.
- Reports the number of cleared rows to the score/level logic.

Parameters:
- word_width_p, 10, playfield width in cells (bits per row).
- size_p, 20, playfield height in rows. Row 0 is the top row; row size_p-1 is the bottom row.

Ports:
- clk_i  input  1  clock.
- reset_i  input  1  asynchronous, active-low reset.
- start_i  input  1  request a clear pass; accepted only in IDLE with mem_ready_i=1.
- ready_o  output  1  high in IDLE only.
- done_o  output  1  one-cycle pulse at the end of a pass.
- lines_cleared_o  output  $clog2(size_p)+1  number of rows cleared by the last pass; held until the next accepted start.
- mem_ready_i  input  1  memory is in normal (non-block) mode.
- rd_addr_o  output  $clog2(size_p)  line read address.
- rd_v_o  output  1  read address valid.
- rd_data_i  input  word_width_p  row data, valid the cycle after rd_v_o (memory registers the address).
- wr_addr_o  output  $clog2(size_p)  line write address.
- wr_data_o  output  word_width_p  line write data.
- wr_v_o  output  1  write strobe.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, src_r=dst_r=size_p-1, src_exh_r=0, count_r=0.
  - Output values during reset: ready_o=1, done_o=0, lines_cleared_o=0, rd_v_o=0, wr_v_o=0, all addresses 0, wr_data_o=0.
- States: IDLE, READ, EVAL, FILL, DONE.
- IDLE:
  - On start_i & mem_ready_i: src_r<=size_p-1, dst_r<=size_p-1, src_exh_r<=0, count_r<=0, go to READ.
  - start_i without mem_ready_i is ignored.
- READ:
  - rd_v_o=1, rd_addr_o=src_r. Go to EVAL.
  - If mem_ready_i=0, stall in READ with rd_v_o=0.
- EVAL (rd_data_i valid):
  - full = &rd_data_i.
  - If full: count_r++; no write.
  - Else: wr_v_o=1 only if src_r!=dst_r, with wr_addr_o=dst_r, wr_data_o=rd_data_i. Then dst_r--, except when dst_r==0.
  - If src_r==0: go to FILL if rows remain to be zeroed (count_r after update >0), else go to DONE. Otherwise src_r--, go to READ.
  - If mem_ready_i=0 in EVAL: no write and no state change. Read data remains valid because the memory holds the registered address.
- FILL:
  - wr_v_o=1, wr_addr_o=dst_r, wr_data_o=0.
  - If dst_r==0, go to DONE; else dst_r--.
  - Exactly count_r rows are zeroed (rows 0..count_r-1).
  - Stall with wr_v_o=0 while mem_ready_i=0.
- DONE: done_o=1 for one cycle; lines_cleared_o=count_r. Go to IDLE.
- lines_cleared_o is registered from count_r on entry to DONE and is stable afterwards.
- Only one of rd_v_o and wr_v_o is ever high in a given cycle.
- Latency with no stalls: 2·size_p cycles (READ+EVAL per row) + count cleared rows (FILL) + 1 (DONE) after the start cycle.
  - Pass with no clears: done_o asserts 41 cycles after start for size_p=20.
- Full rows are identified before compaction; the algorithm clears non-adjacent full rows correctly in one pass.
- count_r never exceeds size_p; its width is sized for size_p inclusive.
- Reset mid-pass aborts immediately to the reset state. Memory contents may be partially compacted; the pass is not resumed.
- No $display or other simulation-only side effects in synthesised paths.

Test Plan:
- Empty field, start_i pulse -> 20 reads and no writes; done_o at cycle 41; lines_cleared_o=0.
- Row 19 full (10'h3FF), row 18=10'h001, rows 0-17 zero -> row 19 reads back 10'h001 and row 18 reads back 0; lines_cleared_o=1; exactly one FILL write, to row 0.
- Rows 19,17 full; row 18=10'h0F0; row 16=10'h00F -> final row19=10'h0F0, row18=10'h00F, rows 0-1 zero; lines_cleared_o=2; done_o at cycle 2·20+2+1=43.
- Rows 16-19 full, others zero -> all rows zero; lines_cleared_o=4; 4 FILL writes to rows 0-3.
- mem_ready_i held low for 5 cycles during EVAL of row 10 -> no rd_v_o/wr_v_o while low; final memory identical to the unstalled run; done_o delayed by 5 cycles.
- reset_i asserted low mid-FILL -> outputs return to reset values in the same cycle, asynchronously; ready_o=1 after release; a following start_i runs a clean pass.
